fifo_4bit_8deep: RTL and testbench

FIFO_4BIT_8DEEP -- requirements
Module: fifo_4bit_8deep

---
 rtl/fifo_4bit_8deep_pkg.sv | 9 +
 rtl/fifo_pointer.sv | 25 ++
 rtl/fifo_4bit_8deep.sv | 84 ++++++++
 tb/tb_fifo_4bit_8deep.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_4bit_8deep_pkg.sv
// fifo_4bit_8deep_pkg: shared FIFO sizing constants.
//   FIFO_WIDTH - default data width in bits
//   FIFO_DEPTH - default entry count (power of two)
//   FIFO_PTR_W - pointer width for the default depth
package fifo_4bit_8deep_pkg;
    localparam int FIFO_WIDTH = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
endpackage

// File: rtl/fifo_pointer.sv
// fifo_pointer: modulo-DEPTH counter with increment enable.
//   clk - clock, rising edge
//   rst - asynchronous active-high reset, clears the pointer to 0
//   inc - advance the pointer by one this cycle
//   ptr - current pointer value
module fifo_pointer
    import fifo_4bit_8deep_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inc,
    output logic [$clog2(DEPTH)-1:0]   ptr
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] ptr_q, ptr_d;
    // DEPTH is a power of two, so natural binary overflow is the modulo wrap.
    always_comb ptr_d = inc ? ptr_q + PW'(1) : ptr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
    assign ptr = ptr_q;
endmodule

// File: rtl/fifo_4bit_8deep.sv
// fifo_4bit_8deep: synchronous FIFO with registered read data and flags.
//   Module_clock        - clock, rising edge
//   Module_reset        - asynchronous active-high reset
//   Module_write_enable - write request
//   Module_input        - write data
//   Module_read_enable  - read request
//   Module_output       - read data, loaded on an accepted read
//   Module_valid        - Module_output was loaded on the last edge
//   Module_full         - count == DEPTH
//   Module_empty        - count == 0
//   Module_count        - stored entries, 0..DEPTH
module fifo_4bit_8deep
    import fifo_4bit_8deep_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     Module_clock,
    input  logic                     Module_reset,
    input  logic                     Module_write_enable,
    input  logic [WIDTH-1:0]         Module_input,
    input  logic                     Module_read_enable,
    output logic [WIDTH-1:0]         Module_output,
    output logic                     Module_valid,
    output logic                     Module_full,
    output logic                     Module_empty,
    output logic [$clog2(DEPTH):0]   Module_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d, full_q, full_d, empty_q, empty_d;
    logic             rd_acc, wr_acc;
    always_comb begin
        rd_acc  = Module_read_enable && !empty_q;
        // A full FIFO still takes a write when a read frees a slot in the same cycle.
        wr_acc  = Module_write_enable && (!full_q || rd_acc);
        count_d = (wr_acc && !rd_acc) ? count_q + CW'(1) :
                  (rd_acc && !wr_acc) ? count_q - CW'(1) : count_q;
        full_d  = count_d == CW'(DEPTH);
        empty_d = count_d == '0;
        valid_d = rd_acc;
        out_d   = rd_acc ? mem_q[rd_ptr] : out_q;
    end
    always_ff @(posedge Module_clock or posedge Module_reset) begin
        if (Module_reset) begin
            count_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end
    // Storage is never reset; the pointer reset discards its contents logically.
    always_ff @(posedge Module_clock) begin
        if (wr_acc) mem_q[wr_ptr] <= Module_input;
    end
    fifo_pointer #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (Module_clock),
        .rst (Module_reset),
        .inc (rd_acc),
        .ptr (rd_ptr)
    );
    fifo_pointer #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (Module_clock),
        .rst (Module_reset),
        .inc (wr_acc),
        .ptr (wr_ptr)
    );
    assign Module_output = out_q;
    assign Module_valid  = valid_q;
    assign Module_full   = full_q;
    assign Module_empty  = empty_q;
    assign Module_count  = count_q;
endmodule

// File: tb/tb_fifo_4bit_8deep.sv
// tb_fifo_4bit_8deep: randomized and directed checks against a queue model.
module tb_fifo_4bit_8deep;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0;
    logic [3:0] din = '0;
    logic       re = 1'b0;
    logic [3:0] dout;
    logic       valid, full, empty;
    logic [3:0] count;
    logic [3:0] mq[$];
    logic [3:0] mout;
    logic       mvalid;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    fifo_4bit_8deep dut (
        .Module_clock        (clk),
        .Module_reset        (rst),
        .Module_write_enable (we),
        .Module_input        (din),
        .Module_read_enable  (re),
        .Module_output       (dout),
        .Module_valid        (valid),
        .Module_full         (full),
        .Module_empty        (empty),
        .Module_count        (count)
    );

    task automatic model_reset();
        mq.delete();
        mout = 4'h0;
        mvalid = 1'b0;
    endtask

    // Drives one cycle of requests and advances the queue model; returns at edge+1.
    task automatic tick(input logic w, input logic [3:0] d, input logic r);
        bit rd, wr;
        we = w;
        din = d;
        re = r;
        rd = r && mq.size() != 0;
        wr = w && (mq.size() < 8 || rd);
        @(posedge clk);
        #1;
        mvalid = rd;
        if (rd) mout = mq.pop_front();
        if (wr) mq.push_back(d);
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || valid !== 1'b0 || dout !== 4'h0) begin
            bad++;
            $display("FAIL reset_async count=%0d empty=%b full=%b valid=%b out=%h want 0/1/0/0/0", count, empty, full, valid, dout);
        end
        @(negedge clk) rst = 1'b0;
        tick(1'b0, 4'h9, 1'b1);
        total++;
        if (count !== 4'd0 || empty !== 1'b1 || valid !== 1'b0 || dout !== 4'h0) begin
            bad++;
            $display("FAIL reset_read count=%0d empty=%b valid=%b out=%h want 0/1/0/0", count, empty, valid, dout);
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp [3];
        exp[0] = 4'h3; exp[1] = 4'hA; exp[2] = 4'h5;
        for (int i = 0; i < 3; i++) tick(1'b1, exp[i], 1'b0);
        total++;
        if (count !== 4'd3 || empty !== 1'b0) begin
            bad++;
            $display("FAIL basic_count count=%0d empty=%b want 3/0", count, empty);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 4'h0, 1'b1);
            total++;
            if (dout !== exp[i] || valid !== 1'b1) begin
                bad++;
                $display("FAIL basic_rd%0d out=%h valid=%b want %h/1", i, dout, valid, exp[i]);
            end
        end
        total++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            bad++;
            $display("FAIL basic_empty empty=%b count=%0d want 1/0", empty, count);
        end
        tick(1'b0, 4'h0, 1'b0);
        total++;
        if (valid !== 1'b0 || dout !== 4'h5) begin
            bad++;
            $display("FAIL basic_hold valid=%b out=%h want 0/5", valid, dout);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) tick(1'b1, 4'(i), 1'b0);
        total++;
        if (full !== 1'b1 || count !== 4'd8 || empty !== 1'b0) begin
            bad++;
            $display("FAIL full_flag full=%b count=%0d empty=%b want 1/8/0", full, count, empty);
        end
        tick(1'b1, 4'hF, 1'b0);
        total++;
        if (full !== 1'b1 || count !== 4'd8) begin
            bad++;
            $display("FAIL full_drop full=%b count=%0d want 1/8", full, count);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 4'h0, 1'b1);
            total++;
            if (dout !== 4'(i) || valid !== 1'b1) begin
                bad++;
                $display("FAIL full_rd%0d out=%h valid=%b want %h/1", i, dout, valid, 4'(i));
            end
        end
        total++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0) begin
            bad++;
            $display("FAIL full_drained empty=%b full=%b count=%0d want 1/0/0", empty, full, count);
        end
    endtask

    task automatic test_full_rw();
        logic [3:0] exp [8];
        for (int i = 0; i < 8; i++) begin
            exp[i] = 4'($urandom_range(0, 15));
            tick(1'b1, exp[i], 1'b0);
        end
        tick(1'b1, 4'hC, 1'b1);
        total++;
        if (dout !== exp[0] || valid !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
            bad++;
            $display("FAIL fullrw out=%h valid=%b count=%0d full=%b want %h/1/8/1", dout, valid, count, full, exp[0]);
        end
        for (int i = 1; i < 9; i++) begin
            tick(1'b0, 4'h0, 1'b1);
            total++;
            if (dout !== (i == 8 ? 4'hC : exp[i])) begin
                bad++;
                $display("FAIL fullrw_rd%0d out=%h want %h", i, dout, (i == 8 ? 4'hC : exp[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d;
        for (int i = 0; i < 20; i++) begin
            d = 4'($urandom_range(0, 15));
            tick(1'b1, d, 1'b0);
            total++;
            if (count > 4'd1) begin
                bad++;
                $display("FAIL wrap_cnt%0d count=%0d want <=1", i, count);
            end
            tick(1'b0, 4'h0, 1'b1);
            total++;
            if (dout !== d || valid !== 1'b1 || count !== 4'd0) begin
                bad++;
                $display("FAIL wrap_rd%0d out=%h valid=%b count=%0d want %h/1/0", i, dout, valid, count, d);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) tick(1'b1, 4'(i + 9), 1'b0);
        tick(1'b0, 4'h0, 1'b1);
        total++;
        if (count !== 4'd5 || dout !== 4'h9 || valid !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre count=%0d out=%h valid=%b want 5/9/1", count, dout, valid);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || valid !== 1'b0 || dout !== 4'h0) begin
            bad++;
            $display("FAIL areset_now count=%0d empty=%b full=%b valid=%b out=%h want 0/1/0/0/0", count, empty, full, valid, dout);
        end
        we = 1'b1;
        din = 4'h7;
        re = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (count !== 4'd0 || empty !== 1'b1 || valid !== 1'b0) begin
            bad++;
            $display("FAIL areset_override count=%0d empty=%b valid=%b want 0/1/0", count, empty, valid);
        end
        we = 1'b0;
        re = 1'b0;
        @(negedge clk) rst = 1'b0;
        tick(1'b0, 4'h0, 1'b1);
        total++;
        if (valid !== 1'b0 || dout !== 4'h0 || count !== 4'd0) begin
            bad++;
            $display("FAIL areset_read valid=%b out=%h count=%0d want 0/0/0", valid, dout, count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 99) < (i < 200 ? 35 : 65)));
            total++;
            if (count !== 4'(mq.size()) || full !== (mq.size() == 8) || empty !== (mq.size() == 0) || valid !== mvalid || dout !== mout) begin
                bad++;
                $display("FAIL rand%0d count=%0d full=%b empty=%b valid=%b out=%h want %0d/%b/%b/%b/%h", i, count, full, empty, valid, dout, mq.size(), mq.size() == 8, mq.size() == 0, mvalid, mout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_full_rw();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
